anc_sample_ingress: RTL and testbench

- Upstream feeder for the ANC top level. Accepts reference-mic (x) and error-mic (e) samples that arrive on independent single-cycle strobes.
- Pairs them and buffers the pairs in a small FIFO.
- Presents each pair to the controller as a single-cycle in_valid pulse, gated by the controller's level-sensitive ready signal.
- Decouples ADC arrival jitter from the controller/FIR processing time. Counts dropped and unpaired samples.

---
 rtl/anc_sample_ingress_if.sv | 22 ++
 rtl/anc_sample_ingress.sv | 227 ++++++++++++++++++++++
 tb/tb_anc_sample_ingress.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/anc_sample_ingress_if.sv
// Sample/handshake bundle between the ADC-side feeder, the ingress block and the ANC controller.
// Master is the environment (ADCs + controller); slave is anc_sample_ingress.
interface anc_sample_ingress_if;
  logic        x_valid;
  logic [15:0] x_sample;
  logic        e_valid;
  logic [15:0] e_sample;
  logic        controller_ready;
  logic        in_valid;
  logic [15:0] x_out;
  logic [15:0] e_out;

  modport master (
    output x_valid, x_sample, e_valid, e_sample, controller_ready,
    input  in_valid, x_out, e_out
  );

  modport slave (
    input  x_valid, x_sample, e_valid, e_sample, controller_ready,
    output in_valid, x_out, e_out
  );
endinterface

// File: rtl/anc_sample_ingress.sv
// Pairs x/e mic samples, buffers pairs in a small FIFO and issues them one per ready window.
// Optional DC-removal stage on both channels is enabled by defining ANC_DC_BLOCK_EN.
module anc_sample_ingress #(
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int DC_SHIFT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  anc_sample_ingress_if.slave       bus,
  input  logic                      clr_cnt,
  output logic [AW:0]               fill,
  output logic [15:0]               ovf_cnt,
  output logic [15:0]               unpaired_cnt
);

  if (DEPTH < 2 || DEPTH != (1 << AW) || DC_SHIFT < 0 || DC_SHIFT > 31) begin : g_bad_params
    $error("anc_sample_ingress: DEPTH must be 2**AW and >= 2, DC_SHIFT in 0..31");
  end

  localparam logic [AW:0]   FULL_FILL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FILL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_LO = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   hx_q, hx_d, he_q, he_d;
  logic          hx_full_q, hx_full_d, he_full_q, he_full_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [15:0]   ovf_q, ovf_d, unp_q, unp_d;
  logic          in_valid_q, in_valid_d;
  logic [15:0]   x_out_q, x_out_d, e_out_q, e_out_d;

  logic          push_s, pop_s, push_acc_s, drop_s, unp_inc_s, fifo_full_s;
  logic [31:0]   head_s;
  logic [15:0]   x_proc_s, e_proc_s;

  // Pair completion, FIFO push/pop decisions and holding-register updates.
  always_comb begin
    push_s      = hx_full_q && he_full_q;
    fifo_full_s = (fill_q == FULL_FILL);
    pop_s       = (state_q == ST_IDLE) && (fill_q != '0) && bus.controller_ready;
    push_acc_s  = push_s && (!fifo_full_s || pop_s);
    drop_s      = push_s && fifo_full_s && !pop_s;
    head_s      = mem_q[rd_ptr_q];

    hx_d      = bus.x_valid ? bus.x_sample : hx_q;
    he_d      = bus.e_valid ? bus.e_sample : he_q;
    unp_inc_s = 1'b0;
    if (push_s) begin
      // Flags clear with the push; a strobe in this cycle refills the emptied register.
      hx_full_d = bus.x_valid;
      he_full_d = bus.e_valid;
    end else begin
      hx_full_d = hx_full_q || bus.x_valid;
      he_full_d = he_full_q || bus.e_valid;
      unp_inc_s = (bus.x_valid && hx_full_q && !he_full_q) ||
                  (bus.e_valid && he_full_q && !hx_full_q);
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push_acc_s) begin
      mem_d[wr_ptr_q] = {hx_q, he_q};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    case ({push_acc_s, pop_s})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase
  end

  // Saturating drop/unpaired counters; clear beats a simultaneous increment.
  always_comb begin
    if (clr_cnt) begin
      ovf_d = 16'h0000;
      unp_d = 16'h0000;
    end else begin
      ovf_d = (drop_s && ovf_q != 16'hFFFF) ? (ovf_q + 16'd1) : ovf_q;
      unp_d = (unp_inc_s && unp_q != 16'hFFFF) ? (unp_q + 16'd1) : unp_q;
    end
  end

  // Issue handshake: one pulse per pop, then wait for ready to drop before re-arming.
  always_comb begin
    state_d    = state_q;
    in_valid_d = 1'b0;
    x_out_d    = x_out_q;
    e_out_d    = e_out_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d    = ST_ISSUE;
          in_valid_d = 1'b1;
          x_out_d    = x_proc_s;
          e_out_d    = e_proc_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!bus.controller_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_LO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ANC_DC_BLOCK_EN
  function automatic logic signed [16:0] dc_diff(input logic [15:0] s, input logic [31:0] m);
    dc_diff = $signed({s[15], s}) - $signed({m[31], m[31:16]});
  endfunction

  function automatic logic [15:0] sat16(input logic signed [16:0] d);
    if (d > 17'sd32767) begin
      sat16 = 16'h7FFF;
    end else if (d < -17'sd32768) begin
      sat16 = 16'h8000;
    end else begin
      sat16 = d[15:0];
    end
  endfunction

  function automatic logic [31:0] dc_mean_next(input logic [31:0] m, input logic signed [16:0] d);
    logic signed [32:0] step;
    step = $signed({d, 16'h0000}) >>> DC_SHIFT;
    dc_mean_next = m + step[31:0];
  endfunction

  logic [31:0]        mx_q, mx_d, me_q, me_d;
  logic signed [16:0] dx_s, de_s;

  // DC removal on the FIFO head; the leaky means only move when a pair is popped.
  always_comb begin
    dx_s     = dc_diff(head_s[31:16], mx_q);
    de_s     = dc_diff(head_s[15:0], me_q);
    x_proc_s = sat16(dx_s);
    e_proc_s = sat16(de_s);
    if (pop_s) begin
      mx_d = dc_mean_next(mx_q, dx_s);
      me_d = dc_mean_next(me_q, de_s);
    end else begin
      mx_d = mx_q;
      me_d = me_q;
    end
  end

  // DC mean registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mx_q <= 32'h0000_0000;
      me_q <= 32'h0000_0000;
    end else begin
      mx_q <= mx_d;
      me_q <= me_d;
    end
  end
`else
  // Raw pass-through of the FIFO head.
  always_comb begin
    x_proc_s = head_s[31:16];
    e_proc_s = head_s[15:0];
  end
`endif

  // State registers; reset also empties the FIFO and suppresses any pending pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hx_q       <= 16'h0000;
      he_q       <= 16'h0000;
      hx_full_q  <= 1'b0;
      he_full_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      ovf_q      <= 16'h0000;
      unp_q      <= 16'h0000;
      in_valid_q <= 1'b0;
      x_out_q    <= 16'h0000;
      e_out_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      hx_q       <= hx_d;
      he_q       <= he_d;
      hx_full_q  <= hx_full_d;
      he_full_q  <= he_full_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      ovf_q      <= ovf_d;
      unp_q      <= unp_d;
      in_valid_q <= in_valid_d;
      x_out_q    <= x_out_d;
      e_out_q    <= e_out_d;
    end
  end

  assign bus.in_valid  = in_valid_q;
  assign bus.x_out     = x_out_q;
  assign bus.e_out     = e_out_q;
  assign fill          = fill_q;
  assign ovf_cnt       = ovf_q;
  assign unpaired_cnt  = unp_q;

endmodule

// File: tb/tb_anc_sample_ingress.sv
// Randomized + directed bench for anc_sample_ingress (default build, DEPTH=4),
// checked every cycle against a queue-based reference model.
module tb_anc_sample_ingress;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_cnt;
  logic [AW:0]   fill;
  logic [15:0]   ovf_cnt, unpaired_cnt;

  anc_sample_ingress_if bus_if();

  anc_sample_ingress #(.DEPTH(DEPTH), .AW(AW), .DC_SHIFT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .clr_cnt      (clr_cnt),
    .fill         (fill),
    .ovf_cnt      (ovf_cnt),
    .unpaired_cnt (unpaired_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: holding slots, FIFO as a queue, issue window tracking.
  logic [15:0] m_hx, m_he;
  bit          m_hx_full, m_he_full;
  logic [31:0] m_q[$];
  int          m_phase;   // 0 ready to issue, 1 pulse this cycle, 2 waiting for ready low
  logic [15:0] m_x, m_e;
  int          m_ovf, m_unp;

  task automatic model_step(input logic rst, input logic xv, input logic [15:0] xs,
                            input logic ev, input logic [15:0] es, input logic rdy,
                            input logic clr);
    bit pop, push, full_at_start;
    int unp_inc, drop;
    logic [31:0] pair, head;
    if (!rst) begin
      m_q.delete();
      m_hx = 16'h0; m_he = 16'h0; m_hx_full = 0; m_he_full = 0;
      m_phase = 0; m_x = 16'h0; m_e = 16'h0; m_ovf = 0; m_unp = 0;
      return;
    end
    pop           = (m_phase == 0) && (m_q.size() > 0) && rdy;
    push          = m_hx_full && m_he_full;
    full_at_start = (m_q.size() == DEPTH);
    pair          = {m_hx, m_he};
    unp_inc       = 0;
    drop          = 0;
    if (push) begin
      m_hx_full = xv;
      m_he_full = ev;
    end else begin
      if (xv && m_hx_full && !m_he_full) unp_inc++;
      if (ev && m_he_full && !m_hx_full) unp_inc++;
      if (xv) m_hx_full = 1;
      if (ev) m_he_full = 1;
    end
    if (xv) m_hx = xs;
    if (ev) m_he = es;
    if (pop) begin
      head = m_q.pop_front();
      m_x  = head[31:16];
      m_e  = head[15:0];
    end
    if (push) begin
      if (full_at_start && !pop) drop = 1;
      else m_q.push_back(pair);
    end
    if (m_phase == 0 && pop) m_phase = 1;
    else if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2 && !rdy) m_phase = 0;
    if (clr) begin
      m_ovf = 0; m_unp = 0;
    end else begin
      m_ovf = (m_ovf + drop > 65535) ? 65535 : m_ovf + drop;
      m_unp = (m_unp + unp_inc > 65535) ? 65535 : m_unp + unp_inc;
    end
  endtask

  int          pulses;
  logic [15:0] last_x, last_e;

  task automatic cycle(input logic rst, input logic xv, input logic [15:0] xs,
                       input logic ev, input logic [15:0] es, input logic rdy,
                       input logic clr);
    @(negedge clk);
    rst_n                   = rst;
    bus_if.x_valid          = xv;
    bus_if.x_sample         = xs;
    bus_if.e_valid          = ev;
    bus_if.e_sample         = es;
    bus_if.controller_ready = rdy;
    clr_cnt                 = clr;
    model_step(rst, xv, xs, ev, es, rdy, clr);
    @(posedge clk);
    #1;
    if (bus_if.in_valid === 1'b1) begin
      pulses++;
      last_x = bus_if.x_out;
      last_e = bus_if.e_out;
    end
    check_value("in_valid", {31'h0, bus_if.in_valid}, {31'h0, (m_phase == 1)});
    check_value("fill", {29'h0, fill}, m_q.size());
    check_value("ovf_cnt", {16'h0, ovf_cnt}, m_ovf);
    check_value("unpaired_cnt", {16'h0, unpaired_cnt}, m_unp);
    check_value("x_out", {16'h0, bus_if.x_out}, {16'h0, m_x});
    check_value("e_out", {16'h0, bus_if.e_out}, {16'h0, m_e});
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, rdy, 1'b0);
  endtask

  int          first_at;
  int          p0;
  logic [15:0] got_x[4], got_e[4];

  initial begin
    rst_n = 1'b0; clr_cnt = 1'b0;
    bus_if.x_valid = 1'b0; bus_if.x_sample = 16'h0;
    bus_if.e_valid = 1'b0; bus_if.e_sample = 16'h0;
    bus_if.controller_ready = 1'b0;
    pulses = 0;

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    check_value("reset_fill", {29'h0, fill}, 32'd0);
    check_value("reset_in_valid", {31'h0, bus_if.in_valid}, 32'd0);
    idle(2, 1'b0);

    // Single pair, ready high: pulse on the third sampled edge after the strobe.
    p0 = pulses; first_at = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) cycle(1'b1, 1'b1, 16'h1234, 1'b1, 16'hFFF0, 1'b1, 1'b0);
      else idle(1, 1'b1);
      if (first_at == 0 && pulses != p0) first_at = k;
    end
    check_value("t1_latency", first_at, 32'd3);
    check_value("t1_pulses", pulses - p0, 32'd1);
    check_value("t1_x", {16'h0, last_x}, 32'h1234);
    check_value("t1_e", {16'h0, last_e}, 32'hFFF0);
    check_value("t1_fill", {29'h0, fill}, 32'd0);
    idle(2, 1'b0);

    // Unpaired overwrite.
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0002, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b1, 16'h0003, 1'b0, 1'b0);
    check_value("t2_unpaired", {16'h0, unpaired_cnt}, 32'd1);
    p0 = pulses;
    idle(5, 1'b1);
    check_value("t2_pulses", pulses - p0, 32'd1);
    check_value("t2_x", {16'h0, last_x}, 32'h0002);
    check_value("t2_e", {16'h0, last_e}, 32'h0003);
    idle(2, 1'b0);

    // Overflow: 6 pairs into a 4-deep FIFO, then drain one per ready window.
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 1'b1, 16'h0100 + 16'(i), 1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
    idle(2, 1'b0);
    check_value("t3_fill", {29'h0, fill}, 32'd4);
    check_value("t3_ovf", {16'h0, ovf_cnt}, 32'd2);
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      idle(4, 1'b1);
      got_x[i] = last_x; got_e[i] = last_e;
      idle(2, 1'b0);
    end
    check_value("t3_pulses", pulses - p0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_value("t3_order_x", {16'h0, got_x[i]}, 32'h0100 + i);
      check_value("t3_order_e", {16'h0, got_e[i]}, 32'h0200 + i);
    end

    // Ready held high: only one issue per window.
    cycle(1'b1, 1'b1, 16'h0AAA, 1'b1, 16'h0BBB, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0CCC, 1'b1, 16'h0DDD, 1'b0, 1'b0);
    idle(2, 1'b0);
    p0 = pulses;
    idle(10, 1'b1);
    check_value("t4_one_pulse", pulses - p0, 32'd1);
    check_value("t4_first_x", {16'h0, last_x}, 32'h0AAA);
    idle(2, 1'b0);
    idle(6, 1'b1);
    check_value("t4_second", pulses - p0, 32'd2);
    check_value("t4_second_x", {16'h0, last_x}, 32'h0CCC);
    check_value("t4_fill", {29'h0, fill}, 32'd0);
    idle(2, 1'b0);

    // Reset with fill=3 and a pending issue window.
    cycle(1'b1, 1'b1, 16'h0011, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0012, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b1, 16'h0300 + 16'(i), 1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);
    check_value("t5_pre_fill", {29'h0, fill}, 32'd3);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    check_value("t5_fill", {29'h0, fill}, 32'd0);
    check_value("t5_in_valid", {31'h0, bus_if.in_valid}, 32'd0);
    check_value("t5_ovf", {16'h0, ovf_cnt}, 32'd0);
    check_value("t5_unp", {16'h0, unpaired_cnt}, 32'd0);
    p0 = pulses;
    idle(5, 1'b1);
    check_value("t5_no_issue", pulses - p0, 32'd0);

    // Randomized traffic.
    begin
      logic rdy;
      rdy = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(7) == 0) rdy = ~rdy;
        cycle(($urandom_range(399) != 0),
              ($urandom_range(2) == 0), 16'($urandom),
              ($urandom_range(2) == 0), 16'($urandom),
              rdy, ($urandom_range(199) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
